apb_master_fsm: RTL and testbench

APB initiator for the AHB-to-APB bridge. It accepts single transfer requests from the bridge's AHB-side front end, decodes the target slave, runs the APB SETUP and ACCESS phases, and returns read data and status. Its outputs drive the APB interface block, which presents PWRITE, PENABLE, PSELx, PADDR and PWDATA to the slaves and returns PRDATA. It adds PREADY wait-state handling and a wait-state timeout.

---
 rtl/apb_master_fsm.sv | 111 +++++++++++
 tb/tb_apb_master_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_fsm.sv
// APB initiator for the AHB-to-APB bridge.
// It decodes one request per transfer, runs SETUP/ACCESS with PREADY wait states and a timeout, and returns a one-cycle response.
module apb_master_fsm #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [2:0]  PSELx,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg;
  logic [7:0] wait_cnt_reg;
  logic [2:0] sel_dec;

  // Each slave owns a 64 MB window starting at 0x8000_0000; bits [31:26] pick the window.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dec
      localparam logic [5:0] REGION = 6'(32 + gi);
      assign sel_dec[gi] = (req_addr[31:26] == REGION);
    end
  endgenerate

  assign req_ready = (state_reg == IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 8'd0;
      PSELx        <= 3'b000;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= 32'd0;
      PWDATA       <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (|sel_dec) begin
              PADDR     <= req_addr;
              PWRITE    <= req_write;
              PWDATA    <= req_wdata;
              PSELx     <= sel_dec;
              PENABLE   <= 1'b0;
              state_reg <= SETUP;
            end else begin
              // Decode miss: answer with an error without touching the APB bus.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end
          end
        end
        SETUP: begin
          PENABLE   <= 1'b1;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b0;
            rsp_rdata    <= PWRITE ? 32'd0 : PRDATA;
            PSELx        <= 3'b000;
            PENABLE      <= 1'b0;
            wait_cnt_reg <= 8'd0;
            state_reg    <= IDLE;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b1;
            rsp_rdata    <= 32'd0;
            PSELx        <= 3'b000;
            PENABLE      <= 1'b0;
            wait_cnt_reg <= 8'd0;
            state_reg    <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed testbench for apb_master_fsm: each task drives one scenario and checks the DUT against hand-computed values.
module tb_apb_master_fsm;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        PWRITE;
  logic        PENABLE;
  logic [2:0]  PSELx;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  int n_vec = 0;
  int n_err = 0;

  apb_master_fsm #(.TIMEOUT(16)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .PWRITE    (PWRITE),
    .PENABLE   (PENABLE),
    .PSELx     (PSELx),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always #5 HCLK = ~HCLK;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; PRDATA = 32'd0; PREADY = 1'b0;
    tick(); tick();
    n_vec++;
    if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA} !== 69'd0) begin
      n_err++; $display("FAIL reset_apb: got sel=%b en=%b wr=%b addr=%h wdata=%h want all 0", PSELx, PENABLE, PWRITE, PADDR, PWDATA);
    end
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {34'd0, 1'b1}) begin
      n_err++; $display("FAIL reset_rsp: got v=%b e=%b rd=%h rdy=%b want v=0 e=0 rd=0 rdy=1", rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    HRESETn = 1'b1;
    tick();
    $display("reset: released");
  endtask

  task automatic test_write_zero_wait();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'hDEAD_BEEF;
    PREADY = 1'b1; PRDATA = 32'hFFFF_0000;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, req_ready} !== {3'b001, 1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL wr_setup: got sel=%b en=%b wr=%b addr=%h wdata=%h v=%b rdy=%b want 001 0 1 80000010 deadbeef 0 0", PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, req_ready);
    end
    tick();
    n_vec++;
    if ({PSELx, PENABLE, PADDR, rsp_valid} !== {3'b001, 1'b1, 32'h8000_0010, 1'b0}) begin
      n_err++; $display("FAIL wr_access: got sel=%b en=%b addr=%h v=%b want 001 1 80000010 0", PSELx, PENABLE, PADDR, rsp_valid);
    end
    tick();
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata, PSELx, PENABLE, req_ready} !== {1'b1, 1'b0, 32'd0, 3'b000, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL wr_rsp: got v=%b e=%b rd=%h sel=%b en=%b rdy=%b want 1 0 0 000 0 1", rsp_valid, rsp_err, rsp_rdata, PSELx, PENABLE, req_ready);
    end
    tick();
    n_vec++;
    if ({rsp_valid, PADDR, PWDATA, PWRITE} !== {1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1}) begin
      n_err++; $display("FAIL wr_idle_hold: got v=%b addr=%h wdata=%h wr=%b want 0 80000010 deadbeef 1", rsp_valid, PADDR, PWDATA, PWRITE);
    end
    $display("write 80000010 deadbeef: rsp_err=%b rsp_rdata=%h", rsp_err, rsp_rdata);
  endtask

  task automatic test_read_wait_states();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8400_0004; req_wdata = 32'h0;
    PREADY = 1'b0; PRDATA = 32'h0000_1111;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if ({PSELx, PENABLE, PADDR} !== {3'b010, 1'b0, 32'h8400_0004}) begin
      n_err++; $display("FAIL rd_setup: got sel=%b en=%b addr=%h want 010 0 84000004", PSELx, PENABLE, PADDR);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({PSELx, PENABLE, PADDR, rsp_valid} !== {3'b010, 1'b1, 32'h8400_0004, 1'b0}) begin
        n_err++; $display("FAIL rd_access%0d: got sel=%b en=%b addr=%h v=%b want 010 1 84000004 0", i, PSELx, PENABLE, PADDR, rsp_valid);
      end
      if (i == 3) PREADY = 1'b1;
      tick();
    end
    PREADY = 1'b0;
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata, PSELx, PENABLE} !== {1'b1, 1'b0, 32'h0000_1111, 3'b000, 1'b0}) begin
      n_err++; $display("FAIL rd_rsp: got v=%b e=%b rd=%h sel=%b en=%b want 1 0 00001111 000 0", rsp_valid, rsp_err, rsp_rdata, PSELx, PENABLE);
    end
    tick();
    $display("read 84000004 with 3 waits: rsp_rdata=%h", rsp_rdata);
  endtask

  task automatic test_decode_miss();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h9000_0000;
    PRDATA = 32'h1234_5678;
    tick();
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata, PSELx, PENABLE, req_ready} !== {1'b1, 1'b1, 32'd0, 3'b000, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL miss_rsp: got v=%b e=%b rd=%h sel=%b en=%b rdy=%b want 1 1 0 000 0 1", rsp_valid, rsp_err, rsp_rdata, PSELx, PENABLE, req_ready);
    end
    // Second request offered in the response cycle.
    req_addr = 32'h8000_0000; PRDATA = 32'hCAFE_F00D; PREADY = 1'b1;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if ({PSELx, PENABLE, PADDR, rsp_valid} !== {3'b001, 1'b0, 32'h8000_0000, 1'b0}) begin
      n_err++; $display("FAIL miss_next_setup: got sel=%b en=%b addr=%h v=%b want 001 0 80000000 0", PSELx, PENABLE, PADDR, rsp_valid);
    end
    tick(); tick();
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      n_err++; $display("FAIL miss_next_rsp: got v=%b e=%b rd=%h want 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata);
    end
    PREADY = 1'b0;
    tick();
    $display("miss 90000000 then read 80000000: rsp_rdata=%h", rsp_rdata);
  endtask

  task automatic test_timeout();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8800_0000;
    PREADY = 1'b0; PRDATA = 32'h5555_AAAA;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if ({PSELx, PENABLE} !== {3'b100, 1'b0}) begin
      n_err++; $display("FAIL to_setup: got sel=%b en=%b want 100 0", PSELx, PENABLE);
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if ({PSELx, PENABLE, rsp_valid} !== {3'b100, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL to_wait%0d: got sel=%b en=%b v=%b want 100 1 0", i, PSELx, PENABLE, rsp_valid);
      end
      tick();
    end
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata, PSELx, PENABLE, req_ready} !== {1'b1, 1'b1, 32'd0, 3'b000, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL to_abort: got v=%b e=%b rd=%h sel=%b en=%b rdy=%b want 1 1 0 000 0 1", rsp_valid, rsp_err, rsp_rdata, PSELx, PENABLE, req_ready);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL to_pulse: got v=%b want 0", rsp_valid);
    end
    $display("read 88000000 timeout: rsp_err=%b", rsp_err);
  endtask

  task automatic test_reset_mid_transfer();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'hA5A5_5A5A;
    PREADY = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    n_vec++;
    if ({PSELx, PENABLE} !== {3'b001, 1'b1}) begin
      n_err++; $display("FAIL rst_pre: got sel=%b en=%b want 001 1", PSELx, PENABLE);
    end
    HRESETn = 1'b0;
    #1;
    n_vec++;
    if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_rdata} !== 103'd0) begin
      n_err++; $display("FAIL rst_async: got sel=%b en=%b wr=%b addr=%h wdata=%h v=%b e=%b rd=%h want all 0", PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
    HRESETn = 1'b1;
    PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({rsp_valid, req_ready, PSELx} !== {1'b0, 1'b1, 3'b000}) begin
        n_err++; $display("FAIL rst_after%0d: got v=%b rdy=%b sel=%b want 0 1 000", i, rsp_valid, req_ready, PSELx);
      end
    end
    $display("reset during ACCESS: bus idle, req_ready=%b", req_ready);
  endtask

  task automatic test_back_to_back();
    PREADY = 1'b1; PRDATA = 32'h0BAD_F00D;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0000; req_wdata = 32'h0;
    tick();
    n_vec++;
    if ({PSELx, PENABLE, PWRITE} !== {3'b001, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL b2b_setup1: got sel=%b en=%b wr=%b want 001 0 0", PSELx, PENABLE, PWRITE);
    end
    req_write = 1'b1; req_addr = 32'h8400_0000; req_wdata = 32'h7777_8888;
    tick();
    n_vec++;
    if ({PSELx, PENABLE, PADDR, req_ready} !== {3'b001, 1'b1, 32'h8000_0000, 1'b0}) begin
      n_err++; $display("FAIL b2b_access1: got sel=%b en=%b addr=%h rdy=%b want 001 1 80000000 0", PSELx, PENABLE, PADDR, req_ready);
    end
    tick();
    n_vec++;
    if ({rsp_valid, rsp_rdata, PSELx, req_ready} !== {1'b1, 32'h0BAD_F00D, 3'b000, 1'b1}) begin
      n_err++; $display("FAIL b2b_rsp1: got v=%b rd=%h sel=%b rdy=%b want 1 0badf00d 000 1", rsp_valid, rsp_rdata, PSELx, req_ready);
    end
    tick();
    req_valid = 1'b0;
    n_vec++;
    if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b010, 1'b0, 1'b1, 32'h8400_0000, 32'h7777_8888}) begin
      n_err++; $display("FAIL b2b_setup2: got sel=%b en=%b wr=%b addr=%h wdata=%h want 010 0 1 84000000 77778888", PSELx, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tick(); tick();
    n_vec++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'd0}) begin
      n_err++; $display("FAIL b2b_rsp2: got v=%b e=%b rd=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata);
    end
    tick();
    $display("back-to-back read 80000000 / write 84000000: second SETUP 3 cycles after first");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_decode_miss();
    test_timeout();
    test_reset_mid_transfer();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
